odd_parity_serial_tx: RTL and testbench

- Serialiser directly downstream of the 4-bit odd-parity generator.
- Accepts a 4-bit nibble plus its odd-parity bit over a valid/ready handshake.
- Shifts out a framed serial bit stream: start, data LSB-first, parity, stop.
- Each bit is held for a programmable number of clocks; feeds the board-level serial line.

---
 rtl/odd_parity_serial_tx.sv | 175 +++++++++++++++++
 tb/tb_odd_parity_serial_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_parity_serial_tx.sv
// odd_parity_serial_tx: frames a nibble plus its odd-parity bit onto a serial line.
// Frame is start(0), data LSB-first, parity, stop(1); each bit lasts CLKS_PER_BIT clocks.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   data_in    nibble to transmit
//   parity_in  odd-parity bit supplied with data_in
//   valid_in   data_in/parity_in valid
//   ready_out  high in IDLE; a transfer is valid_in && ready_out
//   tx_out     registered serial line, idles high
//   busy       a frame is in progress
//   parity_err one-cycle pulse, aligned with the start bit, when parity_in
//              disagrees with the odd parity of data_in
//
// Optional build macro: ODD_PARITY_SELFCHECK_EN enables the parity self-check.
// Without it parity_err is tied low and no check logic exists.
// DATA_W must stay 4 to match the upstream parity generator.

module odd_parity_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy,
  output logic              parity_err
);

  localparam int TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_W);

  localparam logic [TW-1:0] TMAX =
    TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IMAX =
    IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [TW-1:0]     tmr_q;
  logic [TW-1:0]     tmr_d;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     idx_d;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic              par_q;
  logic              par_d;
  logic              tx_d;
  logic              xfer;
  logic              bit_end;

  assign ready_out = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign xfer      = valid_in && ready_out;
  assign bit_end   = (tmr_q == TMAX);

  // State register. tx_out is registered from the next-state
  // view so the start bit appears in the cycle after the
  // transfer edge, together with busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_out  <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_out  <= tx_d;
    end
  end

  // Next-state logic. Inputs are only sampled on a transfer,
  // so X on data_in/parity_in outside a transfer stays out of
  // the state.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    if (state_q != S_IDLE) begin
      tmr_d = bit_end ? '0 : tmr_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          state_d = S_START;
          shreg_d = data_in;
          par_d   = parity_in;
          idx_d   = '0;
          tmr_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IMAX) begin
            state_d = S_PAR;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line value for the coming cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (1'b1)
      (state_d == S_START): tx_d = 1'b0;
      (state_d == S_DATA):  tx_d = shreg_d[idx_d];
      (state_d == S_PAR):   tx_d = par_d;
      default:              tx_d = 1'b1;
    endcase
  end

`ifdef ODD_PARITY_SELFCHECK_EN
  logic perr_q;

  // Registered so the pulse lines up with the start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= xfer && ((~^data_in) != parity_in);
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// tb_odd_parity_serial_tx: directed plus random frames checked
// against a frame-level model, for CLKS_PER_BIT=4 and 1.

module tb_odd_parity_serial_tx;

  localparam int CPB = 4;

`ifdef ODD_PARITY_SELFCHECK_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data_in;
  logic       parity_in;
  logic       valid_in;
  logic       ready_out;
  logic       tx_out;
  logic       busy;
  logic       parity_err;

  logic [3:0] d1;
  logic       p1;
  logic       v1;
  logic       rdy1;
  logic       tx1;
  logic       busy1;
  logic       perr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  odd_parity_serial_tx #(
    .DATA_W(4),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .parity_in(parity_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .tx_out(tx_out),
    .busy(busy),
    .parity_err(parity_err)
  );

  odd_parity_serial_tx #(
    .DATA_W(4),
    .CLKS_PER_BIT(1)
  ) dut1 (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(d1),
    .parity_in(p1),
    .valid_in(v1),
    .ready_out(rdy1),
    .tx_out(tx1),
    .busy(busy1),
    .parity_err(perr1)
  );

  // Odd parity: bit makes total count of ones odd.
  function automatic logic odd_par(input logic [3:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Serial slot s of a frame: 0 start, 1..4 data LSB first,
  // 5 parity, 6 stop.
  function automatic logic frame_bit(
    input logic [3:0] d, input logic p, input int s);
    logic [6:0] f;
    f = {1'b1, p, d, 1'b0};
    return f[s];
  endfunction

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [3:0] d,
                            input logic p,
                            input bit keep,
                            input logic [3:0] nd,
                            input logic np);
    @(negedge clk);
    chk("ready_before", ready_out, 4'(1'b1));
    chk("line_idle", tx_out, 4'(1'b1));
    data_in   = d;
    parity_in = p;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    if (keep) begin
      data_in   = nd;
      parity_in = np;
    end else begin
      valid_in = 1'b0;
    end
  endtask

  task automatic check_frame(input logic [3:0] d,
                             input logic p,
                             input int ncyc);
    logic pe;
    pe = SC && (p != odd_par(d));
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk("tx_bit", tx_out, 4'(frame_bit(d, p, k / CPB)));
      chk("busy", busy, 4'(1'b1));
      chk("ready_low", ready_out, 4'(1'b0));
      chk("parity_err", parity_err,
          4'((k == 0) ? pe : 1'b0));
      if (!valid_in) begin
        data_in   = 4'($urandom);
        parity_in = 1'($urandom);
        if (k == 6) data_in = 4'h5;
      end
    end
  endtask

  task automatic check_idle();
    @(negedge clk);
    chk("idle_ready", ready_out, 4'(1'b1));
    chk("idle_busy", busy, 4'(1'b0));
    chk("idle_tx", tx_out, 4'(1'b1));
    chk("idle_perr", parity_err, 4'(1'b0));
  endtask

  task automatic fast_frame(input logic [3:0] d,
                            input logic p);
    logic pe;
    pe = SC && (p != odd_par(d));
    @(negedge clk);
    chk("f_ready", rdy1, 4'(1'b1));
    d1 = d;
    p1 = p;
    v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    d1 = 4'($urandom);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("f_tx", tx1, 4'(frame_bit(d, p, k)));
      chk("f_busy", busy1, 4'(1'b1));
      chk("f_perr", perr1, 4'((k == 0) ? pe : 1'b0));
    end
    @(negedge clk);
    chk("f_done_ready", rdy1, 4'(1'b1));
    chk("f_done_tx", tx1, 4'(1'b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] d;
    logic       p;
    data_in   = 4'hx;
    parity_in = 1'bx;
    valid_in  = 1'b0;
    d1 = 4'h0;
    p1 = 1'b0;
    v1 = 1'b0;

    // Reset values
    #12;
    chk("rst_tx", tx_out, 4'(1'b1));
    chk("rst_ready", ready_out, 4'(1'b1));
    chk("rst_busy", busy, 4'(1'b0));
    chk("rst_perr", parity_err, 4'(1'b0));
    chk("rst_tx1", tx1, 4'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with valid low and X on data: no start bit
    repeat (6) begin
      @(negedge clk);
      chk("idle_hold_tx", tx_out, 4'(1'b1));
      chk("idle_hold_busy", busy, 4'(1'b0));
    end

    // Single frame, data changes during frame ignored
    start_xfer(4'b1010, 1'b1, 1'b0, 4'h0, 1'b0);
    check_frame(4'b1010, 1'b1, 7 * CPB);
    check_idle();

    // Back-to-back with valid held high
    start_xfer(4'h0, 1'b1, 1'b1, 4'hF, 1'b1);
    check_frame(4'h0, 1'b1, 7 * CPB);
    check_idle();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check_frame(4'hF, 1'b1, 7 * CPB);
    check_idle();

    // Reset at cycle 10 of a frame
    d = 4'($urandom);
    p = odd_par(d);
    start_xfer(d, p, 1'b0, 4'h0, 1'b0);
    check_frame(d, p, 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_out, 4'(1'b1));
    chk("mid_rst_busy", busy, 4'(1'b0));
    chk("mid_rst_ready", ready_out, 4'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    start_xfer(4'h3, 1'b1, 1'b0, 4'h0, 1'b0);
    check_frame(4'h3, 1'b1, 7 * CPB);
    check_idle();

    // Wrong parity supplied: sent unmodified
    start_xfer(4'h1, 1'b1, 1'b0, 4'h0, 1'b0);
    check_frame(4'h1, 1'b1, 7 * CPB);
    check_idle();

    // Random frames, roughly one in four with bad parity
    repeat (12) begin
      d = 4'($urandom);
      p = ($urandom_range(0, 3) == 0) ? !odd_par(d)
                                      : odd_par(d);
      start_xfer(d, p, 1'b0, 4'h0, 1'b0);
      check_frame(d, p, 7 * CPB);
      check_idle();
    end

    // One clock per bit
    fast_frame(4'h8, 1'b0);
    fast_frame(4'h1, 1'b1);
    repeat (4) begin
      d = 4'($urandom);
      fast_frame(d, odd_par(d));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
